// File: rtl/weight_load_ctrl.sv
// rtl/weight_load_ctrl.sv - weight RAM load / kernel read-sweep controller
module weight_load_ctrl #(
    parameter int          pWEIGHT_DATA_WIDTH = 64,
    parameter logic [31:0] pWEIGHT_BASE_ADDR  = 32'h4000_0000,
    parameter int          pKERNEL_NUM        = 1024,
    parameter int          pBLOCK_RAM_NUM     = 8,
    localparam int         CW = $clog2(pKERNEL_NUM) + 1,
    localparam int         AW = $clog2(pKERNEL_NUM),
    localparam int         WW = (pBLOCK_RAM_NUM > 1) ? $clog2(pBLOCK_RAM_NUM) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic [CW-1:0]                 load_num,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [pWEIGHT_DATA_WIDTH-1:0] s_data,
    output logic                          wr_en,
    output logic [31:0]                   weight_addr,
    output logic [pWEIGHT_DATA_WIDTH-1:0] weight_data,
    input  logic                          run_start,
    input  logic [CW-1:0]                 run_num,
    input  logic                          run_en,
    output logic [AW-1:0]                 kernel_addr,
    output logic                          kernel_valid,
    output logic                          kernel_last,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                        state_q, state_d;
    logic [WW-1:0]                 widx_q, widx_d;
    logic [AW-1:0]                 kidx_q, kidx_d;
    logic [CW-1:0]                 num_q, num_d;
    logic [AW-1:0]                 kernel_addr_q, kernel_addr_d;
    logic                          s_ready_q, s_ready_d;
    logic                          wr_en_q, wr_en_d;
    logic [31:0]                   weight_addr_q, weight_addr_d;
    logic [pWEIGHT_DATA_WIDTH-1:0] weight_data_q, weight_data_d;
    logic                          kernel_valid_q, kernel_valid_d;
    logic                          kernel_last_q, kernel_last_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;

    logic [CW-1:0] cnt_in;
    logic [CW-1:0] last_idx;
    logic          cnt_over;

    always_comb begin
        state_d        = state_q;
        widx_d         = widx_q;
        kidx_d         = kidx_q;
        num_d          = num_q;
        kernel_addr_d  = kernel_addr_q;
        s_ready_d      = 1'b0;
        wr_en_d        = 1'b0;
        weight_addr_d  = weight_addr_q;
        weight_data_d  = weight_data_q;
        kernel_valid_d = 1'b0;
        kernel_last_d  = 1'b0;
        err_d          = err_q;

        // load wins over run when both start pulses land together
        cnt_in   = load_start ? load_num : run_num;
        cnt_over = (cnt_in > CW'(pKERNEL_NUM));
        last_idx = num_q - CW'(1);

        case (state_q)
            S_IDLE: begin
                if (load_start || run_start) begin
                    num_d         = cnt_over ? CW'(pKERNEL_NUM) : cnt_in;
                    err_d         = cnt_over;
                    widx_d        = '0;
                    kidx_d        = '0;
                    kernel_addr_d = '0;
                    if (cnt_in == '0) begin
                        state_d = S_DONE;
                    end else if (load_start) begin
                        state_d   = S_LOAD;
                        s_ready_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_LOAD: begin
                s_ready_d = s_ready_q;
                // s_ready low inside LOAD means the final write is on the bus now
                if (!s_ready_q) begin
                    state_d = S_DONE;
                end else if (s_valid) begin
                    wr_en_d       = 1'b1;
                    weight_data_d = s_data;
                    weight_addr_d = pWEIGHT_BASE_ADDR + 32'(kidx_q);
                    if (widx_q == WW'(pBLOCK_RAM_NUM - 1)) begin
                        widx_d = '0;
                        kidx_d = kidx_q + AW'(1);
                        if ({1'b0, kidx_q} == last_idx) begin
                            s_ready_d = 1'b0;
                        end
                    end else begin
                        widx_d = widx_q + WW'(1);
                    end
                end
            end
            S_RUN: begin
                if (run_en) begin
                    kernel_valid_d = 1'b1;
                    if ({1'b0, kernel_addr_q} == last_idx) begin
                        kernel_last_d = 1'b1;
                        state_d       = S_DONE;
                    end else begin
                        kernel_addr_d = kernel_addr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            widx_q         <= '0;
            kidx_q         <= '0;
            num_q          <= '0;
            kernel_addr_q  <= '0;
            s_ready_q      <= 1'b0;
            wr_en_q        <= 1'b0;
            weight_addr_q  <= '0;
            weight_data_q  <= '0;
            kernel_valid_q <= 1'b0;
            kernel_last_q  <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            widx_q         <= widx_d;
            kidx_q         <= kidx_d;
            num_q          <= num_d;
            kernel_addr_q  <= kernel_addr_d;
            s_ready_q      <= s_ready_d;
            wr_en_q        <= wr_en_d;
            weight_addr_q  <= weight_addr_d;
            weight_data_q  <= weight_data_d;
            kernel_valid_q <= kernel_valid_d;
            kernel_last_q  <= kernel_last_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign wr_en        = wr_en_q;
    assign weight_addr  = weight_addr_q;
    assign weight_data  = weight_data_q;
    assign kernel_addr  = kernel_addr_q;
    assign kernel_valid = kernel_valid_q;
    assign kernel_last  = kernel_last_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb/tb_weight_load_ctrl.sv - directed self-checking bench for weight_load_ctrl
module tb_weight_load_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [10:0] load_num;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        wr_en;
    logic [31:0] weight_addr;
    logic [63:0] weight_data;
    logic        run_start;
    logic [10:0] run_num;
    logic        run_en;
    logic [9:0]  kernel_addr;
    logic        kernel_valid;
    logic        kernel_last;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    int          nwr, ndone, lastwr, donec;
    bit          kv_seen;
    logic [31:0] last_addr;

    weight_load_ctrl dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_num(load_num),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_en(wr_en), .weight_addr(weight_addr), .weight_data(weight_data),
        .run_start(run_start), .run_num(run_num), .run_en(run_en),
        .kernel_addr(kernel_addr), .kernel_valid(kernel_valid), .kernel_last(kernel_last),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wdat(input int k);
        return 64'hC0DE_0000_0000_0000 + 64'(k);
    endfunction

    // Issues load_start (run_start may already be raised by the caller) and
    // feeds the stream until the controller returns to idle.
    task automatic do_load(input logic [10:0] num, input bit toggle, input int budget);
        int acc_n;
        bit acc;
        nwr = 0; ndone = 0; lastwr = -1; donec = -1; kv_seen = 0; last_addr = '0;
        acc_n = 0;
        load_start = 1'b1;
        load_num   = num;
        for (int cyc = 0; cyc < budget; cyc++) begin
            acc = s_ready && s_valid;
            step();
            load_start = 1'b0;
            run_start  = 1'b0;
            if (acc) acc_n++;
            if (wr_en) begin
                chk("wr_addr", 64'(weight_addr), 64'(BASE + 32'(nwr / 8)));
                chk("wr_data", weight_data, wdat(nwr));
                last_addr = weight_addr;
                lastwr    = cyc;
                nwr++;
            end
            if (kernel_valid) kv_seen = 1'b1;
            if (done) begin
                ndone++;
                donec = cyc;
            end
            if (!busy) break;
            s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            s_data  = s_valid ? wdat(acc_n) : 64'hDEAD_BEEF_DEAD_BEEF;
        end
        s_valid = 1'b0;
        chk("load_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [9:0] exp_addr [0:5];
        logic       exp_kv   [0:6];
        logic       exp_kl   [0:6];
        logic       exp_done [0:6];
        logic       en_seq   [0:6];

        rst = 1'b1; load_start = 1'b0; load_num = '0; s_valid = 1'b0; s_data = '0;
        run_start = 1'b0; run_num = '0; run_en = 1'b0;
        step();
        step();

        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_weight_addr", 64'(weight_addr), 64'd0);
        chk("rst_weight_data", weight_data, 64'd0);
        chk("rst_kernel_addr", 64'(kernel_addr), 64'd0);
        chk("rst_kv", 64'(kernel_valid), 64'd0);
        chk("rst_kl", 64'(kernel_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        step();

        // two kernels, stream always valid
        do_load(11'd2, 1'b0, 60);
        chk("l2_nwr", 64'(nwr), 64'd16);
        chk("l2_lastwr", 64'(lastwr), 64'd16);
        chk("l2_donec", 64'(donec), 64'd17);
        chk("l2_ndone", 64'(ndone), 64'd1);
        chk("l2_last_addr", 64'(last_addr), 64'(BASE + 32'd1));
        chk("l2_err", 64'(err), 64'd0);

        // one kernel, stream valid every other cycle
        do_load(11'd1, 1'b1, 60);
        chk("l1t_nwr", 64'(nwr), 64'd8);
        chk("l1t_lastwr", 64'(lastwr), 64'd15);
        chk("l1t_donec", 64'(donec), 64'd16);
        chk("l1t_ndone", 64'(ndone), 64'd1);
        chk("l1t_last_addr", 64'(last_addr), 64'(BASE));

        // read sweep of four kernels with one stall
        exp_addr = '{10'd0, 10'd1, 10'd1, 10'd2, 10'd3, 10'd3};
        exp_kv   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_kl   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        en_seq   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        run_start = 1'b1;
        run_num   = 11'd4;
        run_en    = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            run_start = 1'b0;
            if (i < 6) chk($sformatf("run_addr%0d", i), 64'(kernel_addr), 64'(exp_addr[i]));
            chk($sformatf("run_kv%0d", i), 64'(kernel_valid), 64'(exp_kv[i]));
            chk($sformatf("run_kl%0d", i), 64'(kernel_last), 64'(exp_kl[i]));
            chk($sformatf("run_done%0d", i), 64'(done), 64'(exp_done[i]));
            chk($sformatf("run_wr%0d", i), 64'(wr_en), 64'd0);
            run_en = en_seq[i];
        end
        chk("run_idle", 64'(busy), 64'd0);

        // simultaneous starts: load wins, no read sweep
        run_start = 1'b1;
        run_num   = 11'd4;
        run_en    = 1'b1;
        do_load(11'd1, 1'b0, 40);
        run_en = 1'b0;
        chk("both_nwr", 64'(nwr), 64'd8);
        chk("both_no_kv", 64'(kv_seen), 64'd0);

        // over-range count clamps and raises err
        do_load(11'd1029, 1'b0, 9000);
        chk("big_err", 64'(err), 64'd1);
        chk("big_nwr", 64'(nwr), 64'd8192);
        chk("big_last_addr", 64'(last_addr), 64'(BASE + 32'd1023));
        chk("big_ndone", 64'(ndone), 64'd1);

        // zero count: straight to done, clears err
        do_load(11'd0, 1'b0, 10);
        chk("zero_nwr", 64'(nwr), 64'd0);
        chk("zero_donec", 64'(donec), 64'd0);
        chk("zero_ndone", 64'(ndone), 64'd1);
        chk("zero_err", 64'(err), 64'd0);

        // reset in the middle of a load
        load_start = 1'b1;
        load_num   = 11'd4;
        step();
        load_start = 1'b0;
        s_valid    = 1'b1;
        s_data     = wdat(0);
        step();
        s_data = wdat(1);
        step();
        s_data = wdat(2);
        step();
        chk("mid_wr_before", 64'(wr_en), 64'd1);
        rst = 1'b1;
        step();
        chk("abort_wr_en", 64'(wr_en), 64'd0);
        chk("abort_s_ready", 64'(s_ready), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        rst     = 1'b0;
        s_valid = 1'b0;
        step();
        do_load(11'd1, 1'b0, 40);
        chk("restart_nwr", 64'(nwr), 64'd8);
        chk("restart_last_addr", 64'(last_addr), 64'(BASE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
